load_store_unit: RTL and testbench

Pipeline-side initiator for the single-port word-wide data memory: accepts load/store requests from the MEM stage and turns them into word-indexed memory reads and write-enable pulses. Handles byte/halfword access by lane extraction on loads and read-modify-write on stores, because the memory writes only whole words. Sits between the MEM-stage control and `DataMemory`, and returns one response per accepted request.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store initiator for a single-port word-wide data memory: word access, plus
// byte/half loads (lane extract) and stores (read-modify-write) when LSU_SUBWORD_EN is defined.
module load_store_unit #(
    parameter int unsigned MEM = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_writeEn,
    input  logic [31:0] mem_RD
);
    localparam int unsigned IDX_W = 30;
    localparam logic [1:0] SZ_WORD = 2'b10;
`ifdef LSU_SUBWORD_EN
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
`endif

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   lat_idx;
    logic               accept, fault_c;
    logic [31:0]        addr_nxt, wdata_nxt, rdata_nxt, loaded_c;

`ifdef LSU_SUBWORD_EN
    logic               lat_write, lat_signed;
    logic [1:0]         lat_size, lat_lane;
    logic [15:0]        lat_wdata;
    logic [31:0]        merged_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;

    // Lane extraction for loads and lane insertion into the old word for RMW stores
    always_comb begin
        byte_c   = mem_RD[{lat_lane, 3'b000} +: 8];
        half_c   = mem_RD[{lat_lane[1], 4'b0000} +: 16];
        merged_c = mem_RD;
        if (lat_size == SZ_BYTE) merged_c[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
        else                     merged_c[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
        case (lat_size)
            SZ_BYTE: loaded_c = {{24{lat_signed & byte_c[7]}}, byte_c};
            SZ_HALF: loaded_c = {{16{lat_signed & half_c[15]}}, half_c};
            default: loaded_c = mem_RD;
        endcase
    end
`else
    logic unused_ok;
    assign unused_ok = req_signed;
    assign loaded_c  = mem_RD;
`endif

    assign accept = (state == IDLE) && req_valid && req_ready;

    // Reject misaligned, reserved-size and out-of-range requests at accept
    always_comb begin
        fault_c = (req_addr[31:2] >= IDX_W'(MEM));
`ifdef LSU_SUBWORD_EN
        case (req_size)
            SZ_BYTE: ;
            SZ_HALF: if (req_addr[0]) fault_c = 1'b1;
            SZ_WORD: if (req_addr[1:0] != 2'b00) fault_c = 1'b1;
            default: fault_c = 1'b1;
        endcase
`else
        if ((req_size != SZ_WORD) || (req_addr[1:0] != 2'b00)) fault_c = 1'b1;
`endif
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = '0;
        wdata_nxt = '0;
        rdata_nxt = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault_c) begin
                        state_nxt = RESP;
                    end else if (!req_write) begin
                        state_nxt = RD;
                        addr_nxt  = {2'b00, req_addr[31:2]};
`ifdef LSU_SUBWORD_EN
                    end else if (req_size != SZ_WORD) begin
                        state_nxt = RD;
                        addr_nxt  = {2'b00, req_addr[31:2]};
`endif
                    end else begin
                        state_nxt = WR;
                        addr_nxt  = {2'b00, req_addr[31:2]};
                        wdata_nxt = req_wdata;
                    end
                end
            end
            RD: begin
`ifdef LSU_SUBWORD_EN
                if (lat_write) begin
                    state_nxt = WR;
                    addr_nxt  = {2'b00, lat_idx};
                    wdata_nxt = merged_c;
                end else
`endif
                begin
                    state_nxt = RESP;
                    rdata_nxt = loaded_c;
                end
            end
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lat_idx       <= '0;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_fault    <= 1'b0;
            resp_rdata    <= '0;
            mem_address   <= '0;
            mem_writeData <= '0;
            mem_writeEn   <= 1'b0;
`ifdef LSU_SUBWORD_EN
            lat_write     <= 1'b0;
            lat_signed    <= 1'b0;
            lat_size      <= '0;
            lat_lane      <= '0;
            lat_wdata     <= '0;
`endif
        end else begin
            state         <= state_nxt;
            req_ready     <= (state_nxt == IDLE);
            resp_valid    <= (state_nxt == RESP);
            resp_fault    <= accept && fault_c;
            resp_rdata    <= rdata_nxt;
            mem_address   <= addr_nxt;
            mem_writeData <= wdata_nxt;
            mem_writeEn   <= (state_nxt == WR);
            if (accept) begin
                lat_idx    <= req_addr[31:2];
`ifdef LSU_SUBWORD_EN
                lat_write  <= req_write;
                lat_signed <= req_signed;
                lat_size   <= req_size;
                lat_lane   <= req_addr[1:0];
                lat_wdata  <= req_wdata[15:0];
`endif
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic against
// an arithmetic reference model of the memory and response rules.
module tb_load_store_unit;
    localparam int unsigned MEM = 64;
`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, mem_writeEn;
    logic [31:0] resp_rdata, mem_address, mem_writeData, mem_RD;

    logic [31:0] mem     [MEM];
    logic [31:0] ref_mem [MEM];
    int vectors = 0;
    int errors  = 0;

    load_store_unit #(.MEM(MEM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_writeEn(mem_writeEn), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // Word-wide data memory: combinational read, write on the clock edge
    assign mem_RD = (mem_address < 32'(MEM)) ? mem[mem_address[5:0]] : 32'h0;
    always @(posedge clk)
        if (mem_writeEn && (mem_address < 32'(MEM))) mem[mem_address[5:0]] <= mem_writeData;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
    endtask

    // One request, checked against the reference rules
    task automatic txn(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx, lane, width, lat, got_lat, wr_cnt;
        bit flt;
        longint unsigned old, v, mask, nw;
        logic [31:0] got_rd, wr_addr, wr_data;
        logic got_flt;
        idx   = a >> 2;
        lane  = a % 4;
        width = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        flt = (idx >= MEM) || (sz == 2'd3) || (sz == 2'd1 && lane % 2 != 0) ||
              (sz == 2'd2 && lane != 0) || (!SUBWORD && sz != 2'd2);
        lat = flt ? 1 : ((!w || sz == 2'd2) ? 2 : 3);
        old = flt ? 0 : longint'(ref_mem[idx]);
        v = 0;
        nw = 0;
        if (!flt) begin
            mask = ((64'd1 << width) - 1) << (8 * lane);
            v = (old >> (8 * lane)) & ((64'd1 << width) - 1);
            if (sg && v >= (64'd1 << (width - 1))) v = v + 64'h1_0000_0000 - (64'd1 << width);
            nw = (old & ~mask) | ((longint'(wd) & ((64'd1 << width) - 1)) << (8 * lane));
        end

        wait_ready();
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        got_lat = 0; wr_cnt = 0; got_rd = 'x; got_flt = 1'bx; wr_addr = '0; wr_data = '0;
        for (int k = 1; k <= 6 && got_lat == 0; k++) begin
            @(negedge clk);
            if (mem_writeEn) begin
                wr_cnt++;
                wr_addr = mem_address;
                wr_data = mem_writeData;
            end
            if (resp_valid) begin
                got_lat = k;
                got_rd  = resp_rdata;
                got_flt = resp_fault;
            end
        end
        check("latency", 32'(got_lat), 32'(lat));
        check("fault",   32'(got_flt), 32'(flt));
        check("rdata",   got_rd, (w || flt) ? 32'h0 : v[31:0]);
        check("wr_count", 32'(wr_cnt), (w && !flt) ? 32'd1 : 32'd0);
        if (w && !flt) begin
            check("wr_addr", wr_addr, 32'(idx));
            check("wr_data", wr_data, nw[31:0]);
            ref_mem[idx] = nw[31:0];
        end
    endtask

    initial begin
        logic [31:0] saved;
        bit seen;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < int'(MEM); i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        repeat (2) @(negedge clk);
        check("rst_ready",  32'(req_ready),   32'd0);
        check("rst_rvalid", 32'(resp_valid),  32'd0);
        check("rst_fault",  32'(resp_fault),  32'd0);
        check("rst_wen",    32'(mem_writeEn), 32'd0);
        check("rst_rdata",  resp_rdata,       32'h0);
        check("rst_maddr",  mem_address,      32'h0);
        check("rst_mwdata", mem_writeData,    32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        txn(1, 2'd2, 0, 32'h08, 32'hDEADBEEF);
        txn(0, 2'd2, 0, 32'h08, 32'h0);
        txn(1, 2'd2, 0, 32'h08, 32'h11223344);
        txn(1, 2'd0, 0, 32'h09, 32'h000000AA);
        txn(0, 2'd2, 0, 32'h08, 32'h0);
        txn(1, 2'd2, 0, 32'h08, 32'h8000FF80);
        txn(0, 2'd0, 1, 32'h08, 32'h0);
        txn(0, 2'd1, 0, 32'h0A, 32'h0);
        txn(0, 2'd1, 1, 32'h0A, 32'h0);
        txn(1, 2'd2, 0, 32'h06, 32'h12345678);
        txn(0, 2'd1, 0, 32'h03, 32'h0);
        txn(0, 2'd2, 0, 32'h100, 32'h0);
        txn(0, 2'd3, 0, 32'h08, 32'h0);
        txn(1, 2'd1, 0, 32'h0E, 32'h0000BEEF);
        txn(0, 2'd0, 0, 32'hFC, 32'h0);

        // Reset during the first busy cycle of a store: no write, no response
        wait_ready();
        saved = ref_mem[2];
        req_valid = 1'b1; req_write = 1'b1; req_signed = 1'b0;
        req_size = SUBWORD ? 2'd0 : 2'd2;
        req_addr = SUBWORD ? 32'h09 : 32'h08;
        req_wdata = 32'h5A5A5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        seen = resp_valid;
        reset = 1'b0;
        #1;
        check("abort_wen",   32'(mem_writeEn), 32'd0);
        check("abort_maddr", mem_address,      32'h0);
        check("abort_ready", 32'(req_ready),   32'd0);
        repeat (2) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        reset = 1'b1;
        @(negedge clk);
        seen = seen | resp_valid;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);
        seen = seen | resp_valid;
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_mem", mem[2], saved);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {22'd0, 8'($urandom_range(0, 72)), 2'($urandom)};
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        for (int i = 0; i < int'(MEM); i++) check("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
